// File: rtl/aes_key_expand_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aes_key_expand_seq
//
// Sequential AES-128 key schedule feeding the unrolled pipelined decrypt core.
// A key_load captures the cipher key into slot 0. Each following enabled cycle
// derives one more round key from the previous slot until slot NR is written.
// At that point keys_valid rises and stays high until the next load or reset.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   sys_en          global enable; when low every register holds its value
//   key_load        start expansion of cipher_key (sampled only when sys_en=1)
//   cipher_key      AES key; w0 in [127:96], byte 0 in [127:120]
//   busy            high while expansion is in progress (state == EXPAND)
//   keys_valid      high when all NR+1 slots belong to the last loaded key
//   round_keys_flat slot k at [k*128 +: 128]; slot 0 = cipher key
// -----------------------------------------------------------------------------
module aes_key_expand_seq #(
   parameter int NR = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sys_en,
   input  logic                    key_load,
   input  logic [127:0]            cipher_key,
   output logic                    busy,
   output logic                    keys_valid,
   output logic [(NR+1)*128-1:0]   round_keys_flat
);

   localparam int KW = (NR + 1) * 128;

   // Only the AES-128 schedule (Nk=4, 10 rounds) is implemented.
   if (NR != 10) begin : g_nr_check
      $error("aes_key_expand_seq: only NR=10 is supported");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box: multiplicative inverse (a^254, with 0 -> 0) followed by
   // the AES affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31;
      logic [7:0] x62, x63, x126, x127, inv;
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x7   = gf_mul(x6, a);
      x14  = gf_mul(x7, x7);
      x15  = gf_mul(x14, a);
      x30  = gf_mul(x15, x15);
      x31  = gf_mul(x30, a);
      x62  = gf_mul(x31, x31);
      x63  = gf_mul(x62, a);
      x126 = gf_mul(x63, x63);
      x127 = gf_mul(x126, a);
      inv  = gf_mul(x127, x127);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   state_t          state_q, state_d;
   logic            busy_q, busy_d;
   logic            keys_valid_q, keys_valid_d;
   logic [3:0]      counter_q, counter_d;
   logic [7:0]      rcon_q, rcon_d;
   logic [KW-1:0]   keys_q, keys_d;

   // Previous round key; index clamped so IDLE (counter 0) stays in range.
   logic [3:0]      prev_idx;
   logic [127:0]    prev_key;
   logic [31:0]     w0, w1, w2, w3;
   logic [31:0]     rot_w, sub_w, t_w;
   logic [31:0]     n0, n1, n2, n3;
   logic [7:0]      rcon_next;

   assign prev_idx = (counter_q == 4'd0) ? 4'd0 : counter_q - 4'd1;
   assign prev_key = keys_q[prev_idx*128 +: 128];
   assign {w0, w1, w2, w3} = prev_key;

   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sub_word
      assign sub_w[i*8 +: 8] = sbox(rot_w[i*8 +: 8]);
   end

   assign t_w = sub_w ^ {rcon_q, 24'h000000};
   assign n0  = w0 ^ t_w;
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;

   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the
      // block leaves it unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      keys_valid_d = keys_valid_q;
      counter_d    = counter_q;
      rcon_d       = rcon_q;
      keys_d       = keys_q;

      if (sys_en) begin
         if (key_load) begin
            // A load wins in every state and abandons any in-flight step.
            keys_d[127:0] = cipher_key;
            counter_d     = 4'd1;
            rcon_d        = 8'h01;
            state_d       = EXPAND;
            keys_valid_d  = 1'b0;
         end else if (state_q == EXPAND) begin
            keys_d[counter_q*128 +: 128] = {n0, n1, n2, n3};
            rcon_d    = rcon_next;
            counter_d = counter_q + 4'd1;
            if (counter_q == 4'(NR)) begin
               state_d      = DONE;
               keys_valid_d = 1'b1;
            end
         end
      end

      busy_d = (state_d == EXPAND);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         keys_valid_q <= 1'b0;
         counter_q    <= 4'd0;
         rcon_q       <= 8'h01;
         // NOTE: the slot storage is reset too, because IDLE must present an
         // all-zero key bus rather than whatever a previous key left behind.
         keys_q       <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop
         // samples its _d value from before this edge.
         state_q      <= state_d;
         busy_q       <= busy_d;
         keys_valid_q <= keys_valid_d;
         counter_q    <= counter_d;
         rcon_q       <= rcon_d;
         keys_q       <= keys_d;
      end
   end

   assign busy            = busy_q;
   assign keys_valid      = keys_valid_q;
   assign round_keys_flat = keys_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_aes_key_expand_seq
//
// Known-answer vectors (FIPS-197 key and the all-zero key) are held in a
// table. Each load pushes the vectors for its key onto a scoreboard queue; the
// queue is drained and compared once keys_valid rises. Hand-written sequences
// cover the stall, reload, mid-expansion reset and ignored-load cases.
// Edge counts treat the edge that samples key_load as edge 1.
// -----------------------------------------------------------------------------
module tb_aes_key_expand_seq;

   localparam int NR = 10;
   localparam int KW = (NR + 1) * 128;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_KEY = 128'h0;

   typedef struct {
      logic [127:0] key;
      int           slot;
      logic [127:0] exp;
   } vec_t;

   logic            clk;
   logic            rst_n;
   logic            sys_en;
   logic            key_load;
   logic [127:0]    cipher_key;
   logic            busy;
   logic            keys_valid;
   logic [KW-1:0]   round_keys_flat;

   vec_t vecs[$];
   vec_t sb_q[$];
   int   n_cmp;
   int   n_bad;

   aes_key_expand_seq #(.NR(NR)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sys_en          (sys_en),
      .key_load        (key_load),
      .cipher_key      (cipher_key),
      .busy            (busy),
      .keys_valid      (keys_valid),
      .round_keys_flat (round_keys_flat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] slot(input int k);
      return round_keys_flat[k*128 +: 128];
   endfunction

   function automatic logic [127:0] exp_slot(input logic [127:0] key, input int k);
      foreach (vecs[i]) if (vecs[i].key == key && vecs[i].slot == k) return vecs[i].exp;
      return 'x;
   endfunction

   task automatic push_exp(input logic [127:0] key);
      foreach (vecs[i]) if (vecs[i].key == key) sb_q.push_back(vecs[i]);
   endtask

   // Called at a negedge; returns at the negedge after the load edge.
   task automatic start_load(input logic [127:0] key, input string tag);
      sys_en     = 1'b1;
      key_load   = 1'b1;
      cipher_key = key;
      push_exp(key);
      @(posedge clk);
      @(negedge clk);
      key_load = 1'b0;
      check({"load_busy_", tag}, 128'(busy), 128'd1);
      check({"load_valid_", tag}, 128'(keys_valid), 128'd0);
      check({"load_slot0_", tag}, slot(0), key);
   endtask

   // One enabled expansion edge that must not complete the schedule.
   task automatic step_checked(input string tag);
      @(posedge clk);
      @(negedge clk);
      check({"step_busy_", tag}, 128'(busy), 128'd1);
      check({"step_valid_", tag}, 128'(keys_valid), 128'd0);
   endtask

   // Waits (bounded) for keys_valid, checks latency, then drains the scoreboard.
   task automatic wait_valid(input int start_edges, input int exp_edges, input string tag);
      int   edges;
      vec_t v;
      edges = start_edges;
      while (keys_valid !== 1'b1 && edges < 60) begin
         check({"busy_", tag}, 128'(busy), 128'd1);
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check({"latency_", tag}, 128'(edges), 128'(exp_edges));
      check({"done_busy_", tag}, 128'(busy), 128'd0);
      check({"sb_nonempty_", tag}, 128'(sb_q.size() > 0), 128'd1);
      while (sb_q.size() > 0) begin
         v = sb_q.pop_front();
         check($sformatf("slot%0d_%s", v.slot, tag), slot(v.slot), v.exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;

      vecs.push_back('{FIPS_KEY,  1, 128'ha0fafe1788542cb123a339392a6c7605});
      vecs.push_back('{FIPS_KEY,  2, 128'hf2c295f27a96b9435935807a7359f67f});
      vecs.push_back('{FIPS_KEY,  3, 128'h3d80477d4716fe3e1e237e446d7a883b});
      vecs.push_back('{FIPS_KEY,  4, 128'hef44a541a8525b7fb671253bdb0bad00});
      vecs.push_back('{FIPS_KEY,  5, 128'hd4d1c6f87c839d87caf2b8bc11f915bc});
      vecs.push_back('{FIPS_KEY,  6, 128'h6d88a37a110b3efddbf98641ca0093fd});
      vecs.push_back('{FIPS_KEY,  7, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f});
      vecs.push_back('{FIPS_KEY,  8, 128'head27321b58dbad2312bf5607f8d292f});
      vecs.push_back('{FIPS_KEY,  9, 128'hac7766f319fadc2128d12941575c006e});
      vecs.push_back('{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
      vecs.push_back('{ZERO_KEY,  1, 128'h62636363626363636263636362636363});
      vecs.push_back('{ZERO_KEY,  2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa});
      vecs.push_back('{ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e});

      clk        = 1'b0;
      rst_n      = 1'b0;
      sys_en     = 1'b0;
      key_load   = 1'b0;
      cipher_key = '0;

      // Reset state.
      #12;
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_valid", 128'(keys_valid), 128'd0);
      check("rst_flat_zero", 128'(round_keys_flat == '0), 128'd1);

      // IDLE holds the reset values while enabled.
      @(negedge clk);
      rst_n  = 1'b1;
      sys_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("idle_busy", 128'(busy), 128'd0);
      check("idle_valid", 128'(keys_valid), 128'd0);
      check("idle_flat_zero", 128'(round_keys_flat == '0), 128'd1);

      // Plain FIPS-197 expansion.
      start_load(FIPS_KEY, "fips");
      wait_valid(1, 11, "fips");

      // Reset asserted during the sixth step of a reload.
      start_load(FIPS_KEY, "rst");
      for (int i = 0; i < 5; i++) step_checked("rst");
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 128'(busy), 128'd0);
      check("midrst_valid", 128'(keys_valid), 128'd0);
      check("midrst_flat_zero", 128'(round_keys_flat == '0), 128'd1);
      sb_q.delete();
      @(negedge clk);
      check("midrst_hold_flat_zero", 128'(round_keys_flat == '0), 128'd1);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("postrst_idle_busy", 128'(busy), 128'd0);
      check("postrst_idle_flat_zero", 128'(round_keys_flat == '0), 128'd1);

      // Reload after reset, stalled for 3 cycles in front of step 4.
      start_load(FIPS_KEY, "stall");
      for (int i = 0; i < 3; i++) step_checked("stall");
      sys_en   = 1'b0;
      key_load = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("stall_busy", 128'(busy), 128'd1);
         check("stall_valid", 128'(keys_valid), 128'd0);
         check("stall_slot3", slot(3), exp_slot(FIPS_KEY, 3));
         check("stall_slot4_unwritten", slot(4), 128'h0);
         check("stall_slot0", slot(0), FIPS_KEY);
      end
      key_load = 1'b0;
      sys_en   = 1'b1;
      wait_valid(7, 14, "stall");

      // Zero key interrupted by the FIPS key at step 5.
      start_load(ZERO_KEY, "reload_a");
      for (int i = 0; i < 4; i++) step_checked("reload_a");
      check("reload_a_slot2", slot(2), exp_slot(ZERO_KEY, 2));
      sb_q.delete();
      start_load(FIPS_KEY, "reload_b");
      wait_valid(1, 11, "reload_b");

      // In DONE, a load with sys_en low is ignored; with sys_en high it restarts.
      sys_en     = 1'b0;
      key_load   = 1'b1;
      cipher_key = ZERO_KEY;
      @(posedge clk);
      @(negedge clk);
      check("done_ign_valid", 128'(keys_valid), 128'd1);
      check("done_ign_busy", 128'(busy), 128'd0);
      check("done_ign_slot0", slot(0), FIPS_KEY);
      check("done_ign_slot10", slot(10), exp_slot(FIPS_KEY, 10));
      sys_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      key_load = 1'b0;
      check("done_load_valid", 128'(keys_valid), 128'd0);
      check("done_load_busy", 128'(busy), 128'd1);
      check("done_load_slot0", slot(0), ZERO_KEY);
      push_exp(ZERO_KEY);
      wait_valid(1, 11, "zero");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Sequential AES-128 key schedule that sits directly upstream of the unrolled pipelined decrypt core.
- Expands one 128-bit cipher key into NR+1 round keys, one round key per enabled cycle.
- Drives the flat round-key bus that the decrypt core slices as round_keys_flat[k*128 +: 128].
- Raises keys_valid once every slot holds the round keys for the current key.

Parameters:
- NR, 10: number of rounds. Only 10 (AES-128, Nk=4) is supported; any other value is an elaboration error.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sys_en  input  1  global enable; when low, all state freezes.
- key_load  input  1  start expansion of cipher_key. Sampled only when sys_en=1.
- cipher_key  input  128  AES key. Word w0 is in [127:96]; byte 0 is in [127:120].
- busy  output  1  high while expansion is in progress.
- keys_valid  output  1  high when all NR+1 slots match the last loaded key.
- round_keys_flat  output  (NR+1)*128  slot k is at [k*128 +: 128]; slot 0 is the cipher key, slot NR is the last round key.

Behaviour:
- Reset: on async assert, state=IDLE, busy=0, keys_valid=0, round_keys_flat=0, round counter=0, rcon=8'h01.
- Reset deassertion is used synchronously; the first active edge after deassertion behaves as IDLE.
- FSM states: IDLE, EXPAND, DONE. busy is registered and equals (state==EXPAND).
- sys_en=0: no register changes at all, including FSM, counter, rcon, slots and outputs; key_load is ignored.
- Load (sys_en=1, key_load=1, any state):
  - slot0 <= cipher_key; counter <= 1; rcon <= 8'h01.
  - state <= EXPAND; keys_valid <= 0.
  - Slots 1..NR keep stale values until overwritten.
- Reload in EXPAND: key_load has priority and restarts expansion from the new key. The in-flight step is discarded.
- EXPAND step (sys_en=1, key_load=0):
  - Compute slot[counter] from slot[counter-1] = {w0,w1,w2,w3}.
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2.
  - rcon <= xtime(rcon), i.e. shift left 1, XOR 8'h1b when bit7 was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - counter <= counter+1.
- Completion: the step that writes slot NR moves state to DONE and sets keys_valid <= 1 on the same edge.
- Latency: with sys_en continuously high, keys_valid is first high NR+1 = 11 rising edges after the edge that sampled key_load.
- SubWord uses four instances of the codebase's forward S-box. The combinational path is a single S-box plus XOR chain.
- DONE: holds all slots; keys_valid=1 until the next load or reset.
- IDLE: keys_valid=0 and slots hold their reset value.
- Downstream contract: the decrypt core may only be fed data while keys_valid=1. The block does not monitor in-flight decrypt data.
- Reset mid-expansion: immediate return to the reset values listed above; no partial keys_valid.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c loaded, sys_en=1:
  - keys_valid rises exactly 11 edges after the load edge; busy is high for the 10 cycles before it.
  - slot1 = a0fafe1788542cb123a339392a6c7605.
  - slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - slot1 = 62636363626363636263636362636363.
  - slot10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- FIPS key with sys_en pulled low for 3 cycles at step 4:
  - slots, counter and busy frozen during the stall.
  - keys_valid rises 14 edges after load; final slots identical to the unstalled run.
- Zero key loaded, then FIPS key loaded at step 5:
  - keys_valid stays 0 throughout.
  - Final slot10 = d014f9a8…0ca6, rising 11 edges after the second load.
- rst_n asserted at step 6 of the FIPS expansion:
  - All outputs go to 0 immediately, state IDLE.
  - A later reload completes normally.
- In DONE, key_load pulses with sys_en=0: ignored, keys_valid stays 1. The same pulse with sys_en=1 drops keys_valid to 0 on that edge.
